// File: rtl/dma_engine_pkg.sv
// Shared constants for the single-channel DMA engine: register word offsets,
// CTRL/STATUS bit positions and the transfer FSM state encoding.
package dma_engine_pkg;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_FILL   = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FILL   = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_engine_regs.sv
// Register file and device-side responder of the DMA engine. CTRL.fill and
// FILL exist only when DMA_ENGINE_FILL_EN is defined; otherwise they read 0.
module dma_engine_regs
  import dma_engine_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [31:0]          device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [31:0]          device_rdata_o,
  input  logic                 busy,
  input  logic                 done_set,
  input  logic                 err_set,
  output logic [AddrWidth-1:0] src,
  output logic [AddrWidth-1:0] dst,
  output logic [LenWidth-1:0]  len,
  output logic                 start,
  output logic                 fill_mode,
  output logic [31:0]          fill_val,
  output logic                 irq_o
);

  logic [2:0]  reg_idx;
  logic        wr_en;
  logic        rd_en;
  logic        irq_en_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign reg_idx     = device_addr_i[4:2];
  assign unused_addr = ^{device_addr_i[AddrWidth-1:5], device_addr_i[1:0]};
  // Only full-word writes touch the register file.
  assign wr_en = device_req_i && device_we_i && (device_be_i == 4'hF);
  assign rd_en = device_req_i && !device_we_i;
  assign start = wr_en && (reg_idx == REG_CTRL) && device_wdata_i[CTRL_START];

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      src <= '0;
      dst <= '0;
      len <= '0;
    end else if (wr_en && !busy) begin
      case (reg_idx)
        REG_SRC: src <= AddrWidth'({device_wdata_i[31:2], 2'b00});
        REG_DST: dst <= AddrWidth'({device_wdata_i[31:2], 2'b00});
        REG_LEN: len <= device_wdata_i[LenWidth-1:0];
        default: ;
      endcase
    end
  end

  // Hardware set beats a same-cycle software W1C of done/err.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_en && (reg_idx == REG_CTRL)) irq_en_q <= device_wdata_i[CTRL_IRQ_EN];
      if (done_set) begin
        done_q <= 1'b1;
      end else if (wr_en && (reg_idx == REG_STATUS) && device_wdata_i[STAT_DONE]) begin
        done_q <= 1'b0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (wr_en && (reg_idx == REG_STATUS) && device_wdata_i[STAT_ERR]) begin
        err_q <= 1'b0;
      end
    end
  end

`ifdef DMA_ENGINE_FILL_EN
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      fill_mode <= 1'b0;
      fill_val  <= '0;
    end else if (wr_en) begin
      if (reg_idx == REG_CTRL) fill_mode <= device_wdata_i[CTRL_FILL];
      if (reg_idx == REG_FILL) fill_val  <= device_wdata_i;
    end
  end
`else
  assign fill_mode = 1'b0;
  assign fill_val  = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_SRC:    rd_data = 32'(src);
      REG_DST:    rd_data = 32'(dst);
      REG_LEN:    rd_data = 32'(len);
      REG_CTRL:   rd_data = {29'd0, fill_mode, irq_en_q, 1'b0};
      REG_STATUS: rd_data = {29'd0, err_q, done_q, busy};
      REG_FILL:   rd_data = fill_val;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rd_en ? rd_data : '0;
    end
  end

  assign irq_o = done_q & irq_en_q;

endmodule

// File: rtl/dma_engine.sv
// Single-channel memory-to-memory DMA engine: transfer FSM and bus host port.
// Build option DMA_ENGINE_FILL_EN adds a write-only fill mode (see regs).
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [31:0]          device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [31:0]          device_rdata_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [31:0]          host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [31:0]          host_rdata_i,
  input  logic                 host_err_i,
  output logic                 irq_o
);

  // Whole FSM context in one struct so it can be observed as a unit.
  typedef struct packed {
    dma_state_e           state;
    logic                 fill;
    logic [LenWidth-1:0]  remaining;
    logic [AddrWidth-1:0] cur_src;
    logic [AddrWidth-1:0] cur_dst;
    logic [31:0]          data;
  } dma_ctx_t;

  dma_ctx_t             ctx_q, ctx_d;
  logic                 busy;
  logic                 done_set;
  logic                 err_set;
  logic                 start;
  logic                 fill_mode;
  logic [31:0]          fill_val;
  logic [AddrWidth-1:0] src;
  logic [AddrWidth-1:0] dst;
  logic [LenWidth-1:0]  len;

  dma_engine_regs #(
    .AddrWidth(AddrWidth),
    .LenWidth (LenWidth)
  ) u_regs (
    .clk_sys_i      (clk_sys_i),
    .rst_sys_ni     (rst_sys_ni),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .busy           (busy),
    .done_set       (done_set),
    .err_set        (err_set),
    .src            (src),
    .dst            (dst),
    .len            (len),
    .start          (start),
    .fill_mode      (fill_mode),
    .fill_val       (fill_val),
    .irq_o          (irq_o)
  );

  assign busy = (ctx_q.state != ST_IDLE);

  always_comb begin
    ctx_d    = ctx_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (ctx_q.state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_set = 1'b1;
          end else begin
            ctx_d.cur_src   = src;
            ctx_d.cur_dst   = dst;
            ctx_d.remaining = len;
            ctx_d.fill      = fill_mode;
            ctx_d.data      = fill_val;
            ctx_d.state     = fill_mode ? ST_WR_REQ : ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: if (host_gnt_i) ctx_d.state = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_set     = 1'b1;
            ctx_d.state = ST_IDLE;
          end else begin
            ctx_d.data  = host_rdata_i;
            ctx_d.state = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: if (host_gnt_i) ctx_d.state = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_set     = 1'b1;
            ctx_d.state = ST_IDLE;
          end else begin
            ctx_d.cur_src   = ctx_q.cur_src + AddrWidth'(4);
            ctx_d.cur_dst   = ctx_q.cur_dst + AddrWidth'(4);
            ctx_d.remaining = ctx_q.remaining - LenWidth'(1);
            if (ctx_q.remaining == LenWidth'(1)) begin
              done_set    = 1'b1;
              ctx_d.state = ST_IDLE;
            end else begin
              ctx_d.state = ctx_q.fill ? ST_WR_REQ : ST_RD_REQ;
            end
          end
        end
      end
      default: ctx_d.state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      ctx_q <= '0;
    end else begin
      ctx_q <= ctx_d;
    end
  end

  // Host handshake: request and payload are decoded from the registered state,
  // so they stay stable until the cycle that sees host_gnt_i, then drop.
  assign host_req_o   = (ctx_q.state == ST_RD_REQ) || (ctx_q.state == ST_WR_REQ);
  assign host_we_o    = (ctx_q.state == ST_WR_REQ);
  assign host_be_o    = 4'hF;
  assign host_addr_o  = (ctx_q.state == ST_RD_REQ) ? ctx_q.cur_src :
                        (ctx_q.state == ST_WR_REQ) ? ctx_q.cur_dst : '0;
  assign host_wdata_o = (ctx_q.state == ST_WR_REQ) ? ctx_q.data : '0;

endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: register-driven transfers against a memory bus model
// with an ordered expected-transaction queue.
`timescale 1ns/1ps
module tb_dma_engine;
  import dma_engine_pkg::*;

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_ni = 1'b0;
  logic        device_req_i = 1'b0;
  logic [31:0] device_addr_i = '0;
  logic        device_we_i = 1'b0;
  logic [3:0]  device_be_i = '0;
  logic [31:0] device_wdata_i = '0;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;
  logic        host_req_o;
  logic        host_gnt_i;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = '0;
  logic        host_err_i = 1'b0;
  logic        irq_o;

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int gnt_delay = 0;
  int wait_cnt = 0;
  int rd_count = 0;
  int wr_cnt = 0;
  int txn_cnt = 0;
  int err_read_idx = 0;

  dma_engine dut (
    .clk_sys_i      (clk_sys_i),
    .rst_sys_ni     (rst_sys_ni),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .host_req_o     (host_req_o),
    .host_gnt_i     (host_gnt_i),
    .host_addr_o    (host_addr_o),
    .host_we_o      (host_we_o),
    .host_be_o      (host_be_o),
    .host_wdata_o   (host_wdata_o),
    .host_rvalid_i  (host_rvalid_i),
    .host_rdata_i   (host_rdata_i),
    .host_err_i     (host_err_i),
    .irq_o          (irq_o)
  );

  // Clock
  always #5 clk_sys_i = ~clk_sys_i;

  assign host_gnt_i = host_req_o && (wait_cnt >= gnt_delay);

  // Bus model: samples at negedge, answers one cycle after the grant.
  task automatic bus_model();
    logic        acc, stall, we, hit, hold_valid;
    logic [31:0] addr, wdata;
    logic [64:0] obs, exp;
    logic [68:0] snap;
    hold_valid = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk_sys_i);
      acc   = host_req_o && host_gnt_i;
      stall = host_req_o && !host_gnt_i;
      we    = host_we_o;
      addr  = host_addr_o;
      wdata = host_wdata_o;
      hit   = 1'b0;
      if (host_req_o && hold_valid) begin
        checks++;
        if ({host_we_o, host_be_o, host_addr_o, host_wdata_o} !== snap) begin
          failures++;
          $display("FAIL hold_stable: got %h want %h", {host_we_o, host_be_o, host_addr_o, host_wdata_o}, snap);
        end
      end
      hold_valid = stall;
      snap = {host_we_o, host_be_o, host_addr_o, host_wdata_o};
      if (acc) begin
        txn_cnt++;
        obs = {we, addr, we ? wdata : 32'h0};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bus_txn: got unexpected we/addr/data %h, want none", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            failures++;
            $display("FAIL bus_txn: got %h want %h", obs, exp);
          end
        end
        checks++;
        if (host_be_o !== 4'hF) begin
          failures++;
          $display("FAIL host_be: got %h want f", host_be_o);
        end
        if (we) begin
          wr_cnt++;
          mem[addr] = wdata;
        end else begin
          rd_count++;
          hit = (rd_count == err_read_idx);
        end
      end
      @(posedge clk_sys_i);
      #1;
      host_rvalid_i = acc;
      host_err_i    = hit;
      host_rdata_i  = (acc && !we && mem.exists(addr)) ? mem[addr] : 32'h0;
      wait_cnt      = stall ? wait_cnt + 1 : 0;
    end
  endtask

  // Driver tasks
  task automatic dev_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] be = 4'hF);
    @(negedge clk_sys_i);
    device_req_i   = 1'b1;
    device_we_i    = 1'b1;
    device_addr_i  = {27'd0, idx, 2'b00};
    device_be_i    = be;
    device_wdata_i = data;
    @(posedge clk_sys_i);
    #1;
    device_req_i = 1'b0;
    device_we_i  = 1'b0;
  endtask

  task automatic dev_read(input logic [2:0] idx, output logic [31:0] data);
    @(negedge clk_sys_i);
    device_req_i  = 1'b1;
    device_we_i   = 1'b0;
    device_addr_i = {27'd0, idx, 2'b00};
    device_be_i   = 4'hF;
    @(posedge clk_sys_i);
    #1;
    device_req_i = 1'b0;
    checks++;
    if (device_rvalid_o !== 1'b1) begin
      failures++;
      $display("FAIL dev_rvalid: got %b want 1", device_rvalid_o);
    end
    data = device_rdata_o;
  endtask

  task automatic prep_copy(input logic [31:0] src, input logic [31:0] dst, input int n, input int n_push);
    for (int i = 0; i < n; i++) begin
      mem[src + 32'(4 * i)] = $urandom;
      mem[dst + 32'(4 * i)] = 32'h0;
    end
    for (int i = 0; i < n_push; i++) begin
      exp_q.push_back({1'b0, src + 32'(4 * i), 32'h0});
      exp_q.push_back({1'b1, dst + 32'(4 * i), mem[src + 32'(4 * i)]});
    end
    dev_write(REG_SRC, src);
    dev_write(REG_DST, dst);
    dev_write(REG_LEN, 32'(n));
  endtask

  task automatic wait_not_busy();
    logic [31:0] d;
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      dev_read(REG_STATUS, d);
      idle = !d[STAT_BUSY];
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL wait_not_busy: busy still 1 after 300 polls, want 0");
    end
  endtask

  task automatic check_reg(input string name, input logic [2:0] idx, input logic [31:0] want);
    logic [31:0] d;
    dev_read(idx, d);
    checks++;
    if (d !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, d, want);
    end
  endtask

  task automatic check_copy(input string name, input logic [31:0] src, input logic [31:0] dst, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[dst + 32'(4 * i)] !== mem[src + 32'(4 * i)]) begin
        failures++;
        $display("FAIL %s word %0d: got %h want %h", name, i, mem[dst + 32'(4 * i)], mem[src + 32'(4 * i)]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s exp_q: got %0d pending want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_sys_i);
    #1;
    checks++;
    if ({host_req_o, host_we_o, host_addr_o, host_wdata_o, device_rvalid_o, device_rdata_o, irq_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h rvalid=%b rdata=%h irq=%b want all 0",
               host_req_o, host_we_o, host_addr_o, host_wdata_o, device_rvalid_o, device_rdata_o, irq_o);
    end
    @(negedge clk_sys_i);
    rst_sys_ni = 1'b1;
    check_reg("reset_src", REG_SRC, 32'h0);
    check_reg("reset_dst", REG_DST, 32'h0);
    check_reg("reset_len", REG_LEN, 32'h0);
    check_reg("reset_ctrl", REG_CTRL, 32'h0);
    check_reg("reset_status", REG_STATUS, 32'h0);
    check_reg("reset_fill", REG_FILL, 32'h0);
    check_reg("unmapped_7", 3'd7, 32'h0);
  endtask

  task automatic test_copy();
    int cyc = 0;
    int tx0;
    prep_copy(32'h0010_0000, 32'h0010_1000, 4, 4);
    tx0 = txn_cnt;
    dev_write(REG_CTRL, 32'h3);
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(posedge clk_sys_i);
      #1;
      if (irq_o) cyc = i;
    end
    checks++;
    if (cyc != 16) begin
      failures++;
      $display("FAIL copy_cycles: got %0d want 16", cyc);
    end
    checks++;
    if (txn_cnt - tx0 != 8) begin
      failures++;
      $display("FAIL copy_txn_count: got %0d want 8", txn_cnt - tx0);
    end
    check_reg("copy_status", REG_STATUS, 32'h2);
    check_reg("copy_ctrl", REG_CTRL, 32'h2);
    check_copy("copy_data", 32'h0010_0000, 32'h0010_1000, 4);
    dev_write(REG_STATUS, 32'h2);
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL copy_irq_clear: got %b want 0", irq_o);
    end
  endtask

  task automatic test_len_zero();
    int tx0;
    dev_write(REG_LEN, 32'h0);
    tx0 = txn_cnt;
    dev_write(REG_CTRL, 32'h3);
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("FAIL len0_irq: got %b want 1", irq_o);
    end
    repeat (4) @(posedge clk_sys_i);
    checks++;
    if (txn_cnt != tx0) begin
      failures++;
      $display("FAIL len0_no_bus: got %0d txns want 0", txn_cnt - tx0);
    end
    check_reg("len0_status", REG_STATUS, 32'h2);
    dev_write(REG_STATUS, 32'h2);
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL len0_irq_clear: got %b want 0", irq_o);
    end
    check_reg("len0_status_clr", REG_STATUS, 32'h0);
  endtask

  task automatic test_gnt_delay();
    gnt_delay = 3;
    prep_copy(32'h0010_0100, 32'h0010_2000, 3, 3);
    dev_write(REG_CTRL, 32'h1);
    wait_not_busy();
    check_reg("gnt_delay_status", REG_STATUS, 32'h2);
    check_copy("gnt_delay_data", 32'h0010_0100, 32'h0010_2000, 3);
    dev_write(REG_STATUS, 32'h2);
    gnt_delay = 0;
  endtask

  task automatic test_err();
    int wr0;
    prep_copy(32'h0010_0200, 32'h0010_3000, 4, 1);
    exp_q.push_back({1'b0, 32'h0010_0204, 32'h0});
    rd_count = 0;
    err_read_idx = 2;
    wr0 = wr_cnt;
    dev_write(REG_CTRL, 32'h1);
    wait_not_busy();
    check_reg("err_status", REG_STATUS, 32'h4);
    checks++;
    if (wr_cnt - wr0 != 1) begin
      failures++;
      $display("FAIL err_write_count: got %0d want 1", wr_cnt - wr0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL err_exp_q: got %0d pending want 0", exp_q.size());
    end
    err_read_idx = 0;
    dev_write(REG_STATUS, 32'h4);
    check_reg("err_status_clr", REG_STATUS, 32'h0);
  endtask

  task automatic test_busy_writes();
    gnt_delay = 2;
    prep_copy(32'h0010_0300, 32'h0010_4000, 4, 4);
    dev_write(REG_CTRL, 32'h1);
    dev_write(REG_SRC, 32'h0010_5000);
    dev_write(REG_LEN, 32'h1);
    dev_write(REG_DST, 32'h0010_6000);
    dev_write(REG_CTRL, 32'h1);
    check_reg("busy_src_kept", REG_SRC, 32'h0010_0300);
    check_reg("busy_len_kept", REG_LEN, 32'h4);
    wait_not_busy();
    check_reg("busy_status", REG_STATUS, 32'h2);
    check_copy("busy_data", 32'h0010_0300, 32'h0010_4000, 4);
    dev_write(REG_STATUS, 32'h2);
    gnt_delay = 0;
    dev_write(REG_SRC, 32'h0020_0003);
    check_reg("src_align", REG_SRC, 32'h0020_0000);
    dev_write(REG_SRC, 32'h1234_5678, 4'h3);
    check_reg("src_partial_be", REG_SRC, 32'h0020_0000);
    dev_write(3'd6, 32'hFFFF_FFFF);
    check_reg("unmapped_6", 3'd6, 32'h0);
  endtask

  task automatic test_reset_mid();
    int wr0;
    bit seen = 1'b0;
    prep_copy(32'h0010_0400, 32'h0010_7000, 4, 1);
    wr0 = wr_cnt;
    dev_write(REG_CTRL, 32'h3);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk_sys_i);
      #2;
      seen = (wr_cnt != wr0);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rstmid_reach_wr_wait: got no write grant want one");
    end
    rst_sys_ni = 1'b0;
    #1;
    checks++;
    if ({host_req_o, host_we_o, host_addr_o, irq_o} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: got req=%b we=%b addr=%h irq=%b want 0", host_req_o, host_we_o, host_addr_o, irq_o);
    end
    repeat (2) @(posedge clk_sys_i);
    @(negedge clk_sys_i);
    rst_sys_ni = 1'b1;
    check_reg("rstmid_src", REG_SRC, 32'h0);
    check_reg("rstmid_dst", REG_DST, 32'h0);
    check_reg("rstmid_len", REG_LEN, 32'h0);
    check_reg("rstmid_ctrl", REG_CTRL, 32'h0);
    check_reg("rstmid_status", REG_STATUS, 32'h0);
    repeat (8) @(posedge clk_sys_i);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_exp_q: got %0d pending want 0", exp_q.size());
    end
  endtask

`ifdef DMA_ENGINE_FILL_EN
  task automatic test_fill();
    int rd0;
    dev_write(REG_FILL, 32'hA5A5_A5A5);
    dev_write(REG_DST, 32'h0010_8000);
    dev_write(REG_LEN, 32'h3);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'h0010_8000 + 32'(4 * i), 32'hA5A5_A5A5});
    rd0 = rd_count;
    dev_write(REG_CTRL, 32'h5);
    wait_not_busy();
    check_reg("fill_status", REG_STATUS, 32'h2);
    check_reg("fill_ctrl", REG_CTRL, 32'h4);
    check_reg("fill_val", REG_FILL, 32'hA5A5_A5A5);
    checks++;
    if (rd_count != rd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL fill_traffic: got reads=%0d pending=%0d want 0/0", rd_count - rd0, exp_q.size());
    end
    dev_write(REG_STATUS, 32'h2);
  endtask
`else
  task automatic test_fill();
    dev_write(REG_FILL, 32'hA5A5_A5A5);
    check_reg("fill_absent_val", REG_FILL, 32'h0);
    dev_write(REG_CTRL, 32'h4);
    check_reg("fill_absent_ctrl", REG_CTRL, 32'h0);
  endtask
`endif

  initial begin
    fork
      bus_model();
    join_none
    test_reset();
    test_copy();
    test_len_zero();
    test_gnt_delay();
    test_err();
    test_busy_writes();
    test_fill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
